// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// start/done handshake; inputs above 10^DIGITS-1 saturate to all nines with ovf set.
module bin_to_bcd_seq #(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  ovf
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned ScrW = BcdW + BIN_W;
  localparam int unsigned CntW = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 64'd1;
    for (int unsigned i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p;
  endfunction

  localparam longint unsigned MaxVal = pow10(DIGITS) - 64'd1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BIN_W - 1);
  localparam logic [BcdW-1:0] SatBcd  = {DIGITS{4'h9}};

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e            state_q, state_d;
  logic [ScrW-1:0]   scr_q, scr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              ovf_pend_q, ovf_pend_d;
  logic [BcdW-1:0]   bcd_q, bcd_d;
  logic              ovf_q, ovf_d;
  logic [ScrW-1:0]   adj, shifted;

  // One double-dabble step: correct each BCD nibble, then shift the whole scratch.
  always_comb begin
    adj = scr_q;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (scr_q[BIN_W + 4*i +: 4] >= 4'd5) begin
        adj[BIN_W + 4*i +: 4] = scr_q[BIN_W + 4*i +: 4] + 4'd3;
      end
    end
    shifted = adj << 1;
  end

  always_comb begin
    state_d    = state_q;
    scr_d      = scr_q;
    cnt_d      = cnt_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          scr_d      = {{BcdW{1'b0}}, bin};
          cnt_d      = '0;
          ovf_pend_d = 64'(bin) > MaxVal;
          state_d    = StShift;
        end
      end
      StShift: begin
        scr_d = shifted;
        cnt_d = cnt_q + CntW'(1);
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          bcd_d   = ovf_pend_q ? SatBcd : shifted[ScrW-1 -: BcdW];
          ovf_d   = ovf_pend_q;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      scr_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      scr_q      <= scr_d;
      cnt_q      <= cnt_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
    end
  end

  assign ready = (state_q == StIdle);
  assign busy  = (state_q == StShift);
  assign done  = (state_q == StDone);
  assign bcd   = bcd_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and round-trip bench for bin_to_bcd_seq (BIN_W=14, DIGITS=4).
module tb_bin_to_bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [13:0] bin;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  int checks;
  int failures;

  bin_to_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] b;
    logic [15:0] exp_bcd;
    logic        exp_ovf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference BCD-to-binary converter used for the round trip.
  function automatic int bcd2bin(input logic [15:0] d);
    return int'(d[15:12]) * 1000 + int'(d[11:8]) * 100 + int'(d[7:4]) * 10 + int'(d[3:0]);
  endfunction

  // Drive a one-cycle start, then count falling edges until done is seen (bounded).
  task automatic convert(input logic [13:0] b, output logic [15:0] r, output logic o,
                         output int lat);
    @(negedge clk);
    bin   = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) break;
    end
    r = bcd;
    o = ovf;
  endtask

  vec_t        vecs [12];
  logic [15:0] r;
  logic        o;
  int          lat;
  int          ndone;
  int          t [3];
  int          rt_fail;

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    bin      = '0;
    rst_n    = 1'b0;

    vecs[0]  = '{14'd0,     16'h0000, 1'b0};
    vecs[1]  = '{14'd1234,  16'h1234, 1'b0};
    vecs[2]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[3]  = '{14'd10000, 16'h9999, 1'b1};
    vecs[4]  = '{14'd16383, 16'h9999, 1'b1};
    vecs[5]  = '{14'd5,     16'h0005, 1'b0};
    vecs[6]  = '{14'd10,    16'h0010, 1'b0};
    vecs[7]  = '{14'd99,    16'h0099, 1'b0};
    vecs[8]  = '{14'd100,   16'h0100, 1'b0};
    vecs[9]  = '{14'd4321,  16'h4321, 1'b0};
    vecs[10] = '{14'd8765,  16'h8765, 1'b0};
    vecs[11] = '{14'd1009,  16'h1009, 1'b0};

    #12;
    chk("reset_outputs", {27'd0, ready, busy, done, ovf, 1'b0} | {16'd0, bcd},
        {27'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven conversions, including latency and done width.
    for (int i = 0; i < 12; i++) begin
      convert(vecs[i].b, r, o, lat);
      chk($sformatf("latency_%0d", vecs[i].b), lat, 15);
      chk($sformatf("bcd_%0d", vecs[i].b), {16'd0, r}, {16'd0, vecs[i].exp_bcd});
      chk($sformatf("ovf_%0d", vecs[i].b), {31'd0, o}, {31'd0, vecs[i].exp_ovf});
      @(negedge clk);
      chk($sformatf("done_width_%0d", vecs[i].b), {31'd0, done}, 32'd0);
      chk($sformatf("ready_after_%0d", vecs[i].b), {31'd0, ready}, 32'd1);
    end

    // Start pulsed mid-SHIFT is ignored; bcd holds the previous result meanwhile.
    @(negedge clk);
    bin   = 14'd1234;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_bcd_mid_shift", {16'd0, bcd}, {16'd0, 16'h1009});
    chk("busy_mid_shift", {30'd0, busy, ready}, {30'd0, 1'b1, 1'b0});
    bin   = 14'd42;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        r = bcd;
      end
    end
    chk("ignored_start_done_count", ndone, 1);
    chk("ignored_start_result", {16'd0, r}, {16'd0, 16'h1234});

    // Start held high: back-to-back conversions every 16 cycles.
    @(negedge clk);
    bin   = 14'd321;
    start = 1'b1;
    ndone = 0;
    for (int k = 0; k < 80 && ndone < 3; k++) begin
      @(negedge clk);
      if (done) begin
        t[ndone] = k;
        ndone++;
      end
    end
    start = 1'b0;
    chk("held_start_done_count", ndone, 3);
    if (ndone == 3) begin
      chk("held_start_spacing_1", t[1] - t[0], 16);
      chk("held_start_spacing_2", t[2] - t[1], 16);
    end
    chk("held_start_result", {16'd0, bcd}, {16'd0, 16'h0321});
    repeat (20) @(negedge clk);

    // Reset three cycles into a conversion aborts it with no done pulse.
    @(negedge clk);
    bin   = 14'd777;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("abort_outputs", {11'd0, ready, busy, done, ovf, bcd},
        {11'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    convert(14'd777, r, o, lat);
    chk("after_abort_latency", lat, 15);
    chk("after_abort_bcd", {15'd0, o, r}, {15'd0, 1'b0, 16'h0777});

    // Random round trip through the reference BCD-to-binary converter.
    rt_fail = 0;
    for (int n = 0; n < 1000; n++) begin
      logic [13:0] b;
      b = 14'($urandom_range(9999, 0));
      convert(b, r, o, lat);
      checks++;
      if (bcd2bin(r) != int'(b) || o !== 1'b0 || lat != 15) begin
        failures++;
        rt_fail++;
        if (rt_fail <= 5)
          $display("FAIL round_trip: bin=%0d got bcd=0x%0h ovf=%0b lat=%0d expected %0d",
                   b, r, o, lat, b);
      end
    end
    if (rt_fail == 0) $display("Success");
    else $display("Failure");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
